ultrasonic_sensor_scheduler: RTL
================================

// Module: ultrasonic_sensor_scheduler
// PURPOSE
//  Round-robin measurement scheduler for up to NUM_SENSORS HC-SR04 sensors.
//  Grants one sensor per time slot and drives that sensor's 10us trigger.
//  Times the sensor's echo pulse with one shared width counter.
//  Reports the width in clock cycles, tagged with the sensor index, for the distance-conversion stage.
// PARAMETERS
//  NUM_SENSORS      4          number of sensors, 2..8
//  IDX_W            2          index width, $clog2(NUM_SENSORS)
//  WIDTH_W          22         width counter/result width
//  TRIG_CYCLES      500        trigger high time (10us @ 50MHz)
//  SLOT_CYCLES      3000000    slot length per sensor (60ms @ 50MHz)
//  ECHO_WAIT_CYCLES 50000      max cycles from trigger fall to echo rise (1ms)
//  ECHO_MAX_CYCLES  1250000    max echo width (25ms); saturation point
//  Legal only if SLOT_CYCLES > TRIG_CYCLES+ECHO_WAIT_CYCLES+ECHO_MAX_CYCLES+4
//  and ECHO_MAX_CYCLES < 2**WIDTH_W.
// PORTS
//  Clk_i      in   1            system clock
//  Reset_i    in   1            asynchronous reset, active-high
//  Enable_i   in   1            1 = run measurement slots, 0 = stop
//  Mask_i     in   NUM_SENSORS  per-sensor enable, sampled at slot start
//  Echo_i     in   NUM_SENSORS  raw echo lines, asynchronous
//  Trig_o     out  NUM_SENSORS  trigger lines, at most one high at a time
//  Width_o    out  WIDTH_W      measured echo width in clock cycles
//  Index_o    out  IDX_W        sensor index for Width_o
//  Valid_o    out  1            one-cycle result strobe
//  Timeout_o  out  1            result is a timeout (qualified by Valid_o)
//  Busy_o     out  1            a slot is in progress
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; round-robin pointer=NUM_SENSORS-1; counters 0.
//  Echo_i: 2-flop synchronizer on every bit; edge detection uses synced values only.
//  Granting a slot:
//   - IDLE: if Enable_i=1 and Mask_i!=0, select the first set mask bit after the pointer (wrap-around).
//   - Load the pointer with the selected index and enter TRIG on the next cycle.
//   - If Mask_i=0, stay in IDLE.
//  Slot counter: cleared on TRIG entry; counts every cycle of the slot.
//  TRIG: Trig_o[sel]=1 for exactly TRIG_CYCLES cycles, then -> WAIT_RISE.
//  WAIT_RISE:
//   - Wait for a 0->1 edge on synced echo[sel]; a level already high does not count.
//   - On the edge -> MEASURE with width=1.
//   - After ECHO_WAIT_CYCLES cycles with no edge -> timeout, then GUARD.
//  MEASURE: width +1 per cycle while synced echo[sel]=1.
//   - On the falling edge: Valid_o=1 for one cycle, Width_o=width, Timeout_o=0, Index_o=sel -> GUARD.
//   - Width_o equals the Echo_i high time in cycles.
//   - Valid_o rises 3 cycles after the Echo_i fall.
//   - If width reaches ECHO_MAX_CYCLES: timeout, width holds at ECHO_MAX_CYCLES -> GUARD.
//  GUARD:
//   - Idle until the slot counter = SLOT_CYCLES-1.
//   - Then, if Enable_i=1 and Mask_i!=0, grant the next sensor directly.
//   - Slot starts are therefore exactly SLOT_CYCLES apart; otherwise -> IDLE.
//  Width_o/Index_o/Timeout_o hold their last value until the next Valid_o.
//  Busy_o=1 in TRIG, WAIT_RISE, MEASURE, GUARD.
//  Enable_i=0 in any non-IDLE state:
//   - Abort; next cycle Trig_o=0, Busy_o=0, FSM=IDLE, no Valid_o.
//   - The pointer keeps the aborted index, so the aborted sensor counts as served.
//  Echo on non-selected sensors is ignored.
//  Mask_i changes mid-slot take effect at the next slot start.
//  Reset mid-operation: immediate (asynchronous) return to reset state.
// CONFIGURATION
//  HCSR04_TIMEOUT_REPORT_EN defined:
//   - A timeout (no rise, or saturation) emits Valid_o=1 with Timeout_o=1.
//   - Width_o is 0 for no-rise and ECHO_MAX_CYCLES for saturation.
//   - Valid_o is issued on the cycle the timeout is detected.
//  HCSR04_TIMEOUT_REPORT_EN undefined:
//   - Timeouts produce no Valid_o; Timeout_o is tied 0.
// TESTING (NUM_SENSORS=4, TRIG=4, SLOT=100, WAIT=20, MAX=40)
//  Mask=1011, Enable=1, each echo rises 5 cycles after trig fall, high 10 cycles
//   -> Trig order 0,1,3,0; each 4 cycles; slot starts 100 apart; Valid Width=10, Index 0,1,3.
//  No echo on sensor 1 -> macro off: no Valid for index 1, slots stay 100 apart.
//   Macro on: Valid+Timeout, Width=0, 20 cycles after trig fall.
//  Echo stuck high 60 cycles -> macro on: Valid+Timeout, Width=40.
//   Macro off: no Valid; next slot on time.
//  Enable->0 during MEASURE of sensor 1 -> next cycle Trig=0, Busy=0, no Valid.
//   Enable->1 -> sensor 3 granted next.
//  Reset pulse mid-TRIG -> Trig_o=0 and Busy_o=0 without a clock edge.
//   After release -> sensor 0 first.
//  Echo pulse on non-selected sensor 2 -> ignored.
//   Stale-high echo at WAIT_RISE entry -> not counted until it goes low then high.

Source files
------------

// File: rtl/ultrasonic_sensor_scheduler.sv
// Round-robin HC-SR04 scheduler: one sensor per slot, 10us trigger,
// one shared echo-width counter, result tagged with the sensor index.
//
// Ports:
//   Clk_i, Reset_i  clock, asynchronous active-high reset
//   Enable_i        run measurement slots (0 aborts the current slot)
//   Mask_i          per-sensor enable, sampled at each slot start
//   Echo_i          raw asynchronous echo lines
//   Trig_o          trigger lines, at most one high
//   Width_o         echo width in clock cycles
//   Index_o         sensor index belonging to Width_o
//   Valid_o         one-cycle result strobe
//   Timeout_o       result is a timeout (qualified by Valid_o)
//   Busy_o          a slot is in progress
//
// Build option: define HCSR04_TIMEOUT_REPORT_EN to emit a Valid_o with
// Timeout_o=1 on timeouts; left undefined, timeouts are silent and
// Timeout_o stays 0.

module ultrasonic_sensor_scheduler #(
  parameter int NUM_SENSORS      = 4,
  parameter int IDX_W            = 2,
  parameter int WIDTH_W          = 22,
  parameter int TRIG_CYCLES      = 500,
  parameter int SLOT_CYCLES      = 3000000,
  parameter int ECHO_WAIT_CYCLES = 50000,
  parameter int ECHO_MAX_CYCLES  = 1250000
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic                   Enable_i,
  input  logic [NUM_SENSORS-1:0] Mask_i,
  input  logic [NUM_SENSORS-1:0] Echo_i,
  output logic [NUM_SENSORS-1:0] Trig_o,
  output logic [WIDTH_W-1:0]     Width_o,
  output logic [IDX_W-1:0]       Index_o,
  output logic                   Valid_o,
  output logic                   Timeout_o,
  output logic                   Busy_o
);

`ifdef HCSR04_TIMEOUT_REPORT_EN
  localparam bit REPORT_TMO = 1'b1;
`else
  localparam bit REPORT_TMO = 1'b0;
`endif

  localparam int CNT_MAX = (TRIG_CYCLES > ECHO_WAIT_CYCLES) ?
                           TRIG_CYCLES : ECHO_WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SLOT_W  = $clog2(SLOT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_GUARD
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [WIDTH_W-1:0]     width_q, width_d;
  logic [NUM_SENSORS-1:0] sync1_q, sync2_q, sync3_q;
  logic                   valid_q, valid_d;
  logic                   tout_q, tout_d;
  logic [WIDTH_W-1:0]     wout_q, wout_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic             echo_s;
  logic             echo_rise;
  logic             nxt_found;
  logic [IDX_W-1:0] nxt_idx;
  logic             start;

  // sync3_q only delays the synced value for edge detection
  assign echo_s    = sync2_q[ptr_q];
  assign echo_rise = echo_s & ~sync3_q[ptr_q];
  assign start     = Enable_i & nxt_found;

  // first masked-in sensor after the pointer, wrapping around
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int k = 1; k <= NUM_SENSORS; k++) begin
      if (!nxt_found &&
          Mask_i[IDX_W'((int'(ptr_q) + k) % NUM_SENSORS)]) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'((int'(ptr_q) + k) % NUM_SENSORS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    slot_d  = (state_q == S_IDLE) ? '0 : slot_q + SLOT_W'(1);
    width_d = width_q;
    valid_d = 1'b0;
    tout_d  = tout_q;
    wout_d  = wout_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRIG;
          ptr_d   = nxt_idx;
          cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (echo_rise) begin
          state_d = S_MEAS;
          width_d = WIDTH_W'(1);
        end else if (cnt_q == CNT_W'(ECHO_WAIT_CYCLES - 1)) begin
          state_d = S_GUARD;
          if (REPORT_TMO) begin
            valid_d = 1'b1;
            wout_d  = '0;
            idx_d   = ptr_q;
            tout_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MEAS: begin
        if (!echo_s) begin
          state_d = S_GUARD;
          valid_d = 1'b1;
          wout_d  = width_q;
          idx_d   = ptr_q;
          tout_d  = 1'b0;
        end else if (width_q == WIDTH_W'(ECHO_MAX_CYCLES)) begin
          state_d = S_GUARD;
          if (REPORT_TMO) begin
            valid_d = 1'b1;
            wout_d  = width_q;
            idx_d   = ptr_q;
            tout_d  = 1'b1;
          end
        end else begin
          width_d = width_q + WIDTH_W'(1);
        end
      end
      S_GUARD: begin
        if (slot_q == SLOT_W'(SLOT_CYCLES - 1)) begin
          if (start) begin
            state_d = S_TRIG;
            ptr_d   = nxt_idx;
            cnt_d   = '0;
            slot_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort: pointer keeps the aborted sensor, result regs untouched
    if (state_q != S_IDLE && !Enable_i) begin
      state_d = S_IDLE;
      ptr_d   = ptr_q;
      valid_d = 1'b0;
      tout_d  = tout_q;
      wout_d  = wout_q;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NUM_SENSORS - 1);
      cnt_q   <= '0;
      slot_q  <= '0;
      width_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      wout_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      width_q <= width_d;
      sync1_q <= Echo_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      wout_q  <= wout_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    Trig_o = '0;
    if (state_q == S_TRIG) Trig_o[ptr_q] = 1'b1;
  end

  assign Busy_o    = (state_q != S_IDLE);
  assign Valid_o   = valid_q;
  assign Width_o   = wout_q;
  assign Index_o   = idx_q;
  assign Timeout_o = tout_q;

endmodule
